// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// New content is staged through a load/ready handshake and committed only at a frame boundary.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD_CYC = 500,
    parameter int FLASH_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  blank_in,
    input  logic [7:0]  point_in,
    input  logic [7:0]  flash_in,
    input  logic        load,
    output logic        ready,
    output logic [3:0]  hex_out,
    output logic        point_out,
    output logic        blank_out,
    output logic [7:0]  an_out
);
    localparam int CNT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BLK_W   = $clog2(FLASH_DIV);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(FLASH_DIV - 1);

    typedef enum logic {SHOW, GUARD} state_t;

    state_t             state_reg;
    logic [2:0]         digit_idx_reg;
    logic [CNT_W-1:0]   div_cnt_reg;
    logic [BLK_W-1:0]   blink_cnt_reg;
    logic               blink_phase_reg;
    logic               pend_reg;

    logic [31:0] act_data_reg,  stg_data_reg;
    logic [7:0]  act_blank_reg, stg_blank_reg;
    logic [7:0]  act_point_reg, stg_point_reg;
    logic [7:0]  act_flash_reg, stg_flash_reg;

    logic [3:0]  nibble [8];
    logic        frame_end;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
            assign nibble[gi] = act_data_reg[4*gi +: 4];
        end
    endgenerate

    assign frame_end = (state_reg == GUARD) && (div_cnt_reg == GUARD_LAST) && (digit_idx_reg == 3'd7);
    assign ready     = ~pend_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= SHOW;
            digit_idx_reg   <= 3'd0;
            div_cnt_reg     <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            pend_reg        <= 1'b0;
            act_data_reg    <= 32'h0;
            act_blank_reg   <= 8'hFF;
            act_point_reg   <= 8'h00;
            act_flash_reg   <= 8'h00;
            stg_data_reg    <= 32'h0;
            stg_blank_reg   <= 8'hFF;
            stg_point_reg   <= 8'h00;
            stg_flash_reg   <= 8'h00;
        end else begin
            // Blink timebase runs freely, unaffected by scanning or commits.
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BLK_W'(1);
            end

            case (state_reg)
                SHOW: begin
                    if (div_cnt_reg == SCAN_LAST) begin
                        state_reg   <= GUARD;
                        div_cnt_reg <= '0;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + CNT_W'(1);
                    end
                end
                GUARD: begin
                    if (div_cnt_reg == GUARD_LAST) begin
                        state_reg     <= SHOW;
                        div_cnt_reg   <= '0;
                        digit_idx_reg <= digit_idx_reg + 3'd1;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= SHOW;
            endcase

            // A load on the boundary cycle itself only stages; commit waits a full frame.
            if (frame_end && pend_reg) begin
                act_data_reg  <= stg_data_reg;
                act_blank_reg <= stg_blank_reg;
                act_point_reg <= stg_point_reg;
                act_flash_reg <= stg_flash_reg;
                pend_reg      <= 1'b0;
            end else if (load && !pend_reg) begin
                stg_data_reg  <= data_in;
                stg_blank_reg <= blank_in;
                stg_point_reg <= point_in;
                stg_flash_reg <= flash_in;
                pend_reg      <= 1'b1;
            end
        end
    end

    always_comb begin
        hex_out   = nibble[digit_idx_reg];
        an_out    = 8'hFF;
        point_out = 1'b0;
        blank_out = 1'b1;
        if (state_reg == SHOW) begin
            an_out    = ~(8'h01 << digit_idx_reg);
            point_out = act_point_reg[digit_idx_reg];
            blank_out = act_blank_reg[digit_idx_reg] |
                        (act_flash_reg[digit_idx_reg] & blink_phase_reg);
        end
    end
endmodule
